// File: rtl/crc_serial_ctrl_if.sv
// Requester handshake plus serial CRC engine signals for crc_serial_ctrl.
interface crc_serial_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int CRC_W  = 16
);
  logic [1:0]          in_valid;
  logic [2*DATA_W-1:0] in_data;
  logic [1:0]          in_last;
  logic [1:0]          in_ready;
  logic                load;
  logic                crc_in;
  logic                d_finish;
  logic                crc_out;
  logic [CRC_W-1:0]    crc_value;
  logic                crc_valid;
  logic                crc_owner;
  logic                err_underrun;
  logic                busy;

  modport master (
    output in_valid, in_data, in_last, crc_out,
    input  in_ready, load, crc_in, d_finish, crc_value, crc_valid, crc_owner,
           err_underrun, busy
  );

  modport slave (
    input  in_valid, in_data, in_last, crc_out,
    output in_ready, load, crc_in, d_finish, crc_value, crc_valid, crc_owner,
           err_underrun, busy
  );
endinterface

// File: rtl/crc_serial_ctrl.sv
// Round-robin two-requester frame controller: serialises words MSB-first into a serial
// CRC engine (result 3+DATA_W*N+CRC_W cycles after first accept); in_ready only for the grant.
module crc_serial_ctrl #(
  parameter int DATA_W = 8,
  parameter int CRC_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  crc_serial_ctrl_if.slave bus
);
  localparam int BIT_W = $clog2(DATA_W);
  localparam int COL_W = $clog2(CRC_W);

  typedef enum logic [2:0] {IDLE, FIRST, LOAD, SHIFT, FINISH, COLLECT, DONE} state_t;

  state_t state, state_nxt;

  logic              ptr;
  logic              grant;
  logic [DATA_W-1:0] sreg;
  logic [DATA_W-1:0] hold_dat;
  logic              hold_last;
  logic              hold_full;
  logic              cur_last;
  logic              last_seen;
  logic [BIT_W-1:0]  bit_cnt;
  logic [COL_W-1:0]  col_cnt;
  logic [CRC_W-1:0]  crc_acc;
  logic              owner_q;
  logic              err_q;

  logic [DATA_W-1:0] word_dat;
  logic              word_last;
  logic              word_vld;
  logic              rdy;
  logic              accept;
  logic              bit_end;
  logic              col_end;
  logic              underrun;
  logic              ld;
  logic              ser_bit;
  logic              fin;

  assign word_dat  = grant ? bus.in_data[2*DATA_W-1 -: DATA_W] : bus.in_data[DATA_W-1:0];
  assign word_last = bus.in_last[grant];
  assign word_vld  = bus.in_valid[grant];
  assign bit_end   = (bit_cnt == BIT_W'(DATA_W - 1));
  assign col_end   = (col_cnt == COL_W'(CRC_W - 1));
  assign accept    = rdy && word_vld;

  always_comb begin
    state_nxt = state;
    rdy       = 1'b0;
    ld        = 1'b0;
    ser_bit   = 1'b0;
    fin       = 1'b0;
    underrun  = 1'b0;
    case (state)
      IDLE:    if (|bus.in_valid) state_nxt = FIRST;
      FIRST: begin
        rdy = 1'b1;
        if (word_vld) state_nxt = LOAD;
      end
      LOAD: begin
        ld        = 1'b1;
        state_nxt = SHIFT;
      end
      SHIFT: begin
        ser_bit = sreg[DATA_W-1];
        rdy     = !hold_full && !last_seen;
        // A word arriving exactly on the final bit is bypassed, so it is not an underrun.
        if (bit_end) begin
          if (cur_last) begin
            state_nxt = FINISH;
          end else if (!hold_full && !(rdy && word_vld)) begin
            underrun  = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      FINISH: begin
        fin       = 1'b1;
        state_nxt = COLLECT;
      end
      COLLECT: if (col_end) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= 1'b0;
      grant     <= 1'b0;
      sreg      <= '0;
      hold_dat  <= '0;
      hold_last <= 1'b0;
      hold_full <= 1'b0;
      cur_last  <= 1'b0;
      last_seen <= 1'b0;
      bit_cnt   <= '0;
      col_cnt   <= '0;
      crc_acc   <= '0;
      owner_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      err_q <= underrun;
      case (state)
        IDLE: if (|bus.in_valid) grant <= bus.in_valid[ptr] ? ptr : ~ptr;
        FIRST: if (accept) begin
          sreg      <= word_dat;
          cur_last  <= word_last;
          last_seen <= word_last;
          hold_full <= 1'b0;
          bit_cnt   <= '0;
        end
        SHIFT: begin
          sreg    <= {sreg[DATA_W-2:0], 1'b0};
          bit_cnt <= bit_cnt + 1'b1;
          if (bit_end) begin
            bit_cnt <= '0;
            if (!cur_last) begin
              if (hold_full) begin
                sreg      <= hold_dat;
                cur_last  <= hold_last;
                hold_full <= 1'b0;
              end else if (accept) begin
                sreg      <= word_dat;
                cur_last  <= word_last;
                last_seen <= word_last;
              end else begin
                ptr <= ~grant;
              end
            end
          end else if (accept) begin
            hold_dat  <= word_dat;
            hold_last <= word_last;
            hold_full <= 1'b1;
            last_seen <= word_last;
          end
        end
        FINISH: col_cnt <= '0;
        COLLECT: begin
          crc_acc <= {crc_acc[CRC_W-2:0], bus.crc_out};
          col_cnt <= col_cnt + 1'b1;
          if (col_end) owner_q <= grant;
        end
        DONE: ptr <= ~grant;
        default: ;
      endcase
    end
  end

  assign bus.in_ready     = rdy ? (grant ? 2'b10 : 2'b01) : 2'b00;
  assign bus.load         = ld;
  assign bus.crc_in       = ser_bit;
  assign bus.d_finish     = fin;
  assign bus.crc_value    = crc_acc;
  assign bus.crc_valid    = (state == DONE);
  assign bus.crc_owner    = owner_q;
  assign bus.err_underrun = err_q;
  assign bus.busy         = (state != IDLE);
endmodule

// File: tb/tb_crc_serial_ctrl.sv
// Scoreboard bench for crc_serial_ctrl: per-requester word drivers, a behavioural serial
// CRC engine, and a monitor checking frame timing, bit stream, results and aborts.
module tb_crc_serial_ctrl;
  localparam int DATA_W = 8;
  localparam int CRC_W  = 16;

  typedef struct {
    logic [7:0] dat;
    bit         last;
    int         gap;
  } word_t;

  typedef struct {
    bit          abort;
    bit          owner;
    logic [15:0] val;
    int          nw;
    logic [31:0] bits;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic crc_out_r = 1'b0;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;

  word_t       wq[2][$];
  exp_t        exp_q[$];
  logic [15:0] eng_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  crc_serial_ctrl_if #(.DATA_W(DATA_W), .CRC_W(CRC_W)) bus ();

  crc_serial_ctrl #(.DATA_W(DATA_W), .CRC_W(CRC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  for (genvar r = 0; r < 2; r++) begin : g_drv
    logic       v = 1'b0;
    logic [7:0] d = '0;
    logic       l = 1'b0;
    initial begin : drive
      word_t w;
      int    n;
      forever begin
        if (wq[r].size() == 0) begin
          @(posedge clk); #1;
        end else begin
          w = wq[r].pop_front();
          repeat (w.gap) begin @(posedge clk); #1; end
          v = 1'b1; d = w.dat; l = w.last; n = 0;
          while (n < 3000) begin
            @(negedge clk);
            if (bus.in_ready[r]) break;
            n++;
            @(posedge clk); #1;
          end
          @(posedge clk); #1;
          v = 1'b0; d = '0; l = 1'b0;
        end
      end
    end
  end

  assign bus.in_valid = {g_drv[1].v, g_drv[0].v};
  assign bus.in_data  = {g_drv[1].d, g_drv[0].d};
  assign bus.in_last  = {g_drv[1].l, g_drv[0].l};
  assign bus.crc_out  = crc_out_r;

  // Engine: after d_finish in cycle f, CRC bit 15-k appears in cycle f+1+k.
  initial begin : engine
    logic [15:0] v;
    forever begin
      @(negedge clk);
      if (rst && bus.d_finish) begin
        v = (eng_q.size() != 0) ? eng_q.pop_front() : 16'h0000;
        for (int k = 0; k < CRC_W; k++) begin
          @(posedge clk); #1;
          if (!rst) break;
          crc_out_r = v[CRC_W-1-k];
        end
        @(posedge clk); #1;
        crc_out_r = 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic flag(input string name);
    tests++;
    fails++;
    $display("FAIL %s: unexpected event at cycle %0d", name, cyc);
  endtask

  initial begin : monitor
    bit          open, shifting, rst_seen;
    int          t0, nb, idle;
    logic [31:0] got;
    exp_t        e;
    open = 0; shifting = 0; rst_seen = 0; t0 = 0; nb = 0; idle = 0; got = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (!rst_seen) begin
          rst_seen = 1;
          chk("rst_in_ready",     32'(bus.in_ready),     0);
          chk("rst_load",         32'(bus.load),         0);
          chk("rst_crc_in",       32'(bus.crc_in),       0);
          chk("rst_d_finish",     32'(bus.d_finish),     0);
          chk("rst_crc_value",    32'(bus.crc_value),    0);
          chk("rst_crc_valid",    32'(bus.crc_valid),    0);
          chk("rst_crc_owner",    32'(bus.crc_owner),    0);
          chk("rst_err_underrun", 32'(bus.err_underrun), 0);
          chk("rst_busy",         32'(bus.busy),         0);
        end
        open = 0; shifting = 0; idle = 0;
        exp_q.delete();
        continue;
      end
      rst_seen = 0;
      idle++;
      if ($countones(bus.in_ready) > 1) flag("in_ready_onehot");
      if (|(bus.in_ready & bus.in_valid) && !open) begin
        open = 1; t0 = cyc; nb = 0; got = '0;
      end
      if (bus.load) begin
        chk("load_cycle", cyc, t0 + 1);
        chk("load_crc_in", 32'(bus.crc_in), 0);
        shifting = 1; nb = 0; got = '0;
      end else if (bus.d_finish) begin
        shifting = 0;
        if (exp_q.size() == 0 || exp_q[0].abort) begin
          flag("d_finish_unexpected");
        end else begin
          chk("bit_count", nb, 8 * exp_q[0].nw);
          chk("bit_stream", got, exp_q[0].bits);
          chk("d_finish_cycle", cyc, t0 + 2 + 8 * exp_q[0].nw);
        end
      end else if (shifting) begin
        got = {got[30:0], bus.crc_in};
        nb++;
      end
      if (bus.crc_valid) begin
        if (exp_q.size() == 0 || exp_q[0].abort) begin
          flag("crc_valid_unexpected");
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
          e = exp_q.pop_front();
          chk("crc_value", 32'(bus.crc_value), 32'(e.val));
          chk("crc_owner", 32'(bus.crc_owner), 32'(e.owner));
          chk("crc_valid_cycle", cyc, t0 + 3 + 8 * e.nw + CRC_W);
        end
        open = 0; idle = 0;
      end
      if (bus.err_underrun) begin
        if (exp_q.size() == 0 || !exp_q[0].abort) begin
          flag("underrun_unexpected");
          if (exp_q.size() != 0) void'(exp_q.pop_front());
        end else begin
          e = exp_q.pop_front();
          chk("underrun_cycle", cyc, t0 + 2 + 8 * e.nw);
          chk("underrun_busy", 32'(bus.busy), 0);
        end
        open = 0; shifting = 0; idle = 0;
      end
      if (exp_q.size() == 0) idle = 0;
      if (idle > 1500) begin
        flag("watchdog_no_response");
        void'(exp_q.pop_front());
        idle = 0;
      end
    end
  end

  task automatic push_word(input int r, input logic [7:0] dat, input bit last, input int gap);
    word_t w;
    w.dat = dat; w.last = last; w.gap = gap;
    wq[r].push_back(w);
  endtask

  task automatic expect_frame(input bit owner, input logic [15:0] val, input int nw,
                              input logic [31:0] bits);
    exp_t e;
    e.abort = 0; e.owner = owner; e.val = val; e.nw = nw; e.bits = bits;
    exp_q.push_back(e);
    eng_q.push_back(val);
  endtask

  task automatic expect_abort(input int nw);
    exp_t e;
    e.abort = 1; e.owner = 0; e.val = '0; e.nw = nw; e.bits = '0;
    exp_q.push_back(e);
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((exp_q.size() != 0 || bus.busy) && n < 5000);
    if (n >= 5000) begin
      $display("FAIL %s: timed out waiting for idle", name);
      $fatal(1, "stimulus timeout");
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin : stim
    int n;
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    expect_frame(1'b0, 16'hA55A, 1, 32'h31);
    push_word(0, 8'h31, 1'b1, 0);
    wait_idle("single_word");

    expect_frame(1'b1, 16'h1357, 3, 32'h123456);
    push_word(1, 8'h12, 1'b0, 0);
    push_word(1, 8'h34, 1'b0, 0);
    push_word(1, 8'h56, 1'b1, 0);
    wait_idle("multi_word");

    expect_frame(1'b0, 16'h0F0F, 1, 32'hC3);
    expect_frame(1'b1, 16'hF00F, 1, 32'h5A);
    push_word(0, 8'hC3, 1'b1, 0);
    push_word(1, 8'h5A, 1'b1, 0);
    wait_idle("simultaneous_1");

    expect_frame(1'b0, 16'h8001, 1, 32'h81);
    expect_frame(1'b1, 16'h7EE7, 1, 32'h7E);
    push_word(0, 8'h81, 1'b1, 0);
    push_word(1, 8'h7E, 1'b1, 0);
    wait_idle("simultaneous_2");

    expect_abort(1);
    push_word(0, 8'hFF, 1'b0, 0);
    wait_idle("underrun");

    // Second word becomes valid exactly in the cycle of bit 7 of the first.
    expect_frame(1'b0, 16'hBEEF, 2, 32'hA00F);
    push_word(0, 8'hA0, 1'b0, 0);
    push_word(0, 8'h0F, 1'b1, 8);
    wait_idle("bypass");

    expect_frame(1'b0, 16'hF0F0, 1, 32'h66);
    push_word(0, 8'h66, 1'b1, 0);
    n = 0;
    while (!bus.d_finish && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 1000) begin
      $display("FAIL reset_collect: d_finish never seen");
      $fatal(1, "stimulus timeout");
    end
    repeat (6) @(posedge clk);
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);

    expect_frame(1'b0, 16'h1234, 1, 32'h3C);
    expect_frame(1'b1, 16'h4321, 1, 32'h81);
    push_word(0, 8'h3C, 1'b1, 0);
    push_word(1, 8'h81, 1'b1, 0);
    wait_idle("post_reset");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
